// File: rtl/rv32i_types.sv
// Shared cache geometry constants and the responder FSM state type.
//   LINE_BYTES / LINE_WORDS / LINE_BITS : fixed 32-byte, 8-word line
//   OFFSET_W                            : byte-offset width within a line
//   dcache_state_t                      : responder controller states
package rv32i_types;

  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned LINE_BITS  = 256;
  localparam int unsigned OFFSET_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    FILL_DONE
  } dcache_state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Flop-based direct-mapped line storage: tag, valid, dirty and 256-bit data.
//   clk, rst                    : clock, synchronous active-high reset (valid/dirty only)
//   rd_idx -> rd_tag/valid/dirty/line : asynchronous read port
//   wr_idx                      : set written by any of the write operations below
//   fill_en, fill_tag, fill_line: whole-line install, valid=1, dirty=0
//   word_en, word_sel, word_be, word_data : byte-enabled word merge, dirty=1
//   clean_en                    : clear dirty after a writeback
module dcache_line_array
  import rv32i_types::*;
#(
  parameter int unsigned SET_BITS = 3,
  parameter int unsigned TAG_W    = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SET_BITS-1:0]  rd_idx,
  output logic [TAG_W-1:0]     rd_tag,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic [SET_BITS-1:0]  wr_idx,
  input  logic                 fill_en,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [LINE_BITS-1:0] fill_line,
  input  logic                 word_en,
  input  logic [2:0]           word_sel,
  input  logic [3:0]           word_be,
  input  logic [31:0]          word_data,
  input  logic                 clean_en
);

  localparam int unsigned SETS = 1 << SET_BITS;

  logic [LINE_BITS-1:0] data_q [SETS];
  logic [TAG_W-1:0]     tag_q  [SETS];
  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;

  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_en) begin
        valid_q[wr_idx] <= 1'b1;
        dirty_q[wr_idx] <= 1'b0;
      end
      if (word_en)  dirty_q[wr_idx] <= 1'b1;
      if (clean_en) dirty_q[wr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[wr_idx] <= fill_line;
      tag_q[wr_idx]  <= fill_tag;
    end else if (word_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (word_be[b])
          data_q[wr_idx][{word_sel, 2'(b), 3'b000} +: 8] <= word_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache responder.
//   clk, rst                 : clock, synchronous active-high reset
//   ufp_addr/rmask/wmask/wdata : CPU-side request (rmask!=0 read, wmask!=0 write)
//   ufp_rdata, ufp_resp      : registered read word and one-cycle completion pulse
//   dfp_addr/read/write/wdata : memory-side line request
//   dfp_rdata, dfp_resp      : memory line data and completion pulse
module dcache_responder
  import rv32i_types::*;
#(
  parameter int unsigned SET_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          ufp_addr,
  input  logic [3:0]           ufp_rmask,
  input  logic [3:0]           ufp_wmask,
  input  logic [31:0]          ufp_wdata,
  output logic [31:0]          ufp_rdata,
  output logic                 ufp_resp,
  output logic [31:0]          dfp_addr,
  output logic                 dfp_read,
  output logic                 dfp_write,
  output logic [LINE_BITS-1:0] dfp_wdata,
  input  logic [LINE_BITS-1:0] dfp_rdata,
  input  logic                 dfp_resp
);

  localparam int unsigned TAG_W = 32 - OFFSET_W - SET_BITS;

  dcache_state_t state, state_next;

  logic [31:2]          lat_addr;
  logic [3:0]           lat_wmask;
  logic [31:0]          lat_wdata;
  logic                 resp_q, resp_next;
  logic [31:0]          rdata_q;
  logic                 rdata_load;

  logic [SET_BITS-1:0]  rd_idx, wr_idx, lat_idx, ufp_idx;
  logic [TAG_W-1:0]     rd_tag;
  logic                 rd_valid, rd_dirty;
  logic [LINE_BITS-1:0] rd_line;
  logic [2:0]           rd_word_sel;
  logic [31:0]          rd_word;
  logic                 fill_en, word_en, clean_en;
  logic [2:0]           word_sel;
  logic [3:0]           word_be;
  logic [31:0]          word_data;
  logic                 accept, hit;
  logic                 unused_addr_lsbs;

  assign unused_addr_lsbs = ^ufp_addr[1:0];

  assign ufp_idx = ufp_addr[OFFSET_W +: SET_BITS];
  assign lat_idx = lat_addr[OFFSET_W +: SET_BITS];

  // In IDLE the array is addressed by the live request so hits resolve in the
  // accept cycle; in every other state it follows the latched request.
  assign rd_idx      = (state == IDLE) ? ufp_idx : lat_idx;
  assign rd_word_sel = (state == IDLE) ? ufp_addr[4:2] : lat_addr[4:2];
  assign rd_word     = rd_line[{rd_word_sel, 5'b00000} +: 32];

  assign accept = (state == IDLE) && ((|ufp_rmask) || (|ufp_wmask));
  assign hit    = rd_valid && (rd_tag == ufp_addr[31 -: TAG_W]);

  dcache_line_array #(
    .SET_BITS (SET_BITS),
    .TAG_W    (TAG_W)
  ) u_lines (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (rd_idx),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_line   (rd_line),
    .wr_idx    (wr_idx),
    .fill_en   (fill_en),
    .fill_tag  (lat_addr[31 -: TAG_W]),
    .fill_line (dfp_rdata),
    .word_en   (word_en),
    .word_sel  (word_sel),
    .word_be   (word_be),
    .word_data (word_data),
    .clean_en  (clean_en)
  );

  always_comb begin
    state_next = state;
    resp_next  = 1'b0;
    rdata_load = 1'b0;
    fill_en    = 1'b0;
    word_en    = 1'b0;
    clean_en   = 1'b0;
    wr_idx     = lat_idx;
    word_sel   = lat_addr[4:2];
    word_be    = lat_wmask;
    word_data  = lat_wdata;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (hit) begin
            resp_next = 1'b1;
            // A nonzero wmask wins over rmask.
            if (|ufp_wmask) begin
              word_en   = 1'b1;
              wr_idx    = ufp_idx;
              word_sel  = ufp_addr[4:2];
              word_be   = ufp_wmask;
              word_data = ufp_wdata;
            end else begin
              rdata_load = 1'b1;
            end
          end else if (rd_valid && rd_dirty) begin
            state_next = WRITEBACK;
          end else begin
            state_next = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        if (dfp_resp) begin
          clean_en   = 1'b1;
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (dfp_resp) begin
          fill_en    = 1'b1;
          state_next = FILL_DONE;
        end
      end
      FILL_DONE: begin
        resp_next  = 1'b1;
        state_next = IDLE;
        if (|lat_wmask) word_en    = 1'b1;
        else            rdata_load = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      resp_q <= 1'b0;
    end else begin
      state  <= state_next;
      resp_q <= resp_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_addr  <= ufp_addr[31:2];
      lat_wmask <= ufp_wmask;
      lat_wdata <= ufp_wdata;
    end
    if (rdata_load) rdata_q <= rd_word;
  end

  assign ufp_resp  = resp_q;
  assign ufp_rdata = rdata_q;
  assign dfp_read  = (state == ALLOCATE);
  assign dfp_write = (state == WRITEBACK);
  assign dfp_addr  = (state == WRITEBACK) ? {rd_tag, lat_idx, 5'b00000}
                                          : {lat_addr[31:5], 5'b00000};
  assign dfp_wdata = rd_line;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: fills, hits, dirty eviction, abandoned
// request, stray memory response and reset during a fill.
module tb_dcache_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  ufp_addr;
  logic [3:0]   ufp_rmask;
  logic [3:0]   ufp_wmask;
  logic [31:0]  ufp_wdata;
  logic [31:0]  ufp_rdata;
  logic         ufp_resp;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dcache_responder #(.SET_BITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .ufp_addr  (ufp_addr),
    .ufp_rmask (ufp_rmask),
    .ufp_wmask (ufp_wmask),
    .ufp_wdata (ufp_wdata),
    .ufp_rdata (ufp_rdata),
    .ufp_resp  (ufp_resp),
    .dfp_addr  (dfp_addr),
    .dfp_read  (dfp_read),
    .dfp_write (dfp_write),
    .dfp_wdata (dfp_wdata),
    .dfp_rdata (dfp_rdata),
    .dfp_resp  (dfp_resp)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe exclusivity is checked on every falling edge outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      vectors++;
      assert (!(dfp_read === 1'b1 && dfp_write === 1'b1)) else begin
        miscompares++;
        $error("FAIL strobe_overlap: observed read=%b write=%b expected not both", dfp_read, dfp_write);
      end
    end
    assert (!((|ufp_rmask) && (|ufp_wmask))) else $error("illegal request with both masks set");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ufp_addr  = '0;
    ufp_rmask = '0;
    ufp_wmask = '0;
    ufp_wdata = '0;
  endtask

  task automatic req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                     input logic [31:0] wd);
    ufp_addr  = a;
    ufp_rmask = rm;
    ufp_wmask = wm;
    ufp_wdata = wd;
  endtask

  function automatic logic [255:0] mk_line(input logic [15:0] hi);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = {hi, 16'(i)};
    return l;
  endfunction

  logic [255:0] l1, l1m, l2, l3, l4, l5;

  initial begin
    rst = 1'b1;
    idle_in();
    dfp_rdata = '0;
    dfp_resp  = 1'b0;
    l1 = mk_line(16'h1000);
    l1[1*32 +: 32] = 32'hDEAD_BEEF;
    l1[2*32 +: 32] = 32'hAAAA_BBBB;
    l1m = l1;
    l1m[2*32 +: 32] = 32'hAAAA_5678;
    l2 = mk_line(16'h2222);
    l3 = mk_line(16'h3333);
    l4 = mk_line(16'h4444);
    l5 = mk_line(16'h5555);

    // Reset
    tick(); tick();
    chk("rst_resp",  ufp_resp,  1'b0);
    chk("rst_read",  dfp_read,  1'b0);
    chk("rst_write", dfp_write, 1'b0);
    rst = 1'b0;
    tick();

    // Cold read miss of 0x1004
    req(32'h0000_1004, 4'hF, 4'h0, '0);
    tick();
    idle_in();
    chk("m1_read",  dfp_read,  1'b1);
    chk("m1_write", dfp_write, 1'b0);
    chk("m1_addr",  dfp_addr,  32'h0000_1000);
    chk("m1_noresp", ufp_resp, 1'b0);
    tick();
    chk("m1_hold", dfp_read, 1'b1);
    dfp_rdata = l1;
    dfp_resp  = 1'b1;
    tick();
    dfp_resp = 1'b0;
    chk("m1_fd_read",   dfp_read, 1'b0);
    chk("m1_fd_noresp", ufp_resp, 1'b0);
    tick();
    chk("m1_resp",  ufp_resp,  1'b1);
    chk("m1_rdata", ufp_rdata, 32'hDEAD_BEEF);

    // Write hit in the resp cycle, then read-after-write in the next resp cycle
    req(32'h0000_1008, 4'h0, 4'b0011, 32'h1234_5678);
    tick();
    chk("w_resp", ufp_resp, 1'b1);
    req(32'h0000_1008, 4'hF, 4'h0, '0);
    tick();
    idle_in();
    chk("raw_resp",  ufp_resp,  1'b1);
    chk("raw_rdata", ufp_rdata, 32'hAAAA_5678);
    tick();
    chk("raw_single", ufp_resp, 1'b0);

    // Dirty eviction: 0x1100 maps to set 0 with a different tag
    req(32'h0000_1100, 4'hF, 4'h0, '0);
    tick();
    idle_in();
    chk("wb_write", dfp_write, 1'b1);
    chk("wb_read",  dfp_read,  1'b0);
    chk("wb_addr",  dfp_addr,  32'h0000_1000);
    chk("wb_wdata", dfp_wdata, l1m);
    tick();
    chk("wb_hold", dfp_write, 1'b1);
    dfp_resp = 1'b1;
    tick();
    dfp_resp = 1'b0;
    chk("al_write", dfp_write, 1'b0);
    chk("al_read",  dfp_read,  1'b1);
    chk("al_addr",  dfp_addr,  32'h0000_1100);
    dfp_rdata = l2;
    dfp_resp  = 1'b1;
    tick();
    dfp_resp = 1'b0;
    chk("ev_noresp", ufp_resp, 1'b0);
    tick();
    chk("ev_resp",  ufp_resp,  1'b1);
    chk("ev_rdata", ufp_rdata, 32'h2222_0000);

    // Abandoned request: inputs dropped the cycle after accept
    req(32'h0000_2030, 4'hF, 4'h0, '0);
    tick();
    idle_in();
    chk("ab_read", dfp_read, 1'b1);
    chk("ab_addr", dfp_addr, 32'h0000_2020);
    tick();
    chk("ab_noresp1", ufp_resp, 1'b0);
    tick();
    chk("ab_noresp2", ufp_resp, 1'b0);
    dfp_rdata = l3;
    dfp_resp  = 1'b1;
    tick();
    dfp_resp = 1'b0;
    chk("ab_noresp3", ufp_resp, 1'b0);
    tick();
    chk("ab_resp",  ufp_resp,  1'b1);
    chk("ab_rdata", ufp_rdata, 32'h3333_0004);
    // Stray memory response while IDLE is ignored
    dfp_resp = 1'b1;
    tick();
    dfp_resp = 1'b0;
    chk("ab_single",   ufp_resp,  1'b0);
    chk("stray_read",  dfp_read,  1'b0);
    chk("stray_write", dfp_write, 1'b0);
    tick();
    chk("stray_noresp", ufp_resp, 1'b0);
    // Filled line now hits with one-cycle latency
    req(32'h0000_2030, 4'hF, 4'h0, '0);
    tick();
    idle_in();
    chk("hit_resp",  ufp_resp,  1'b1);
    chk("hit_rdata", ufp_rdata, 32'h3333_0004);
    chk("hit_noread", dfp_read, 1'b0);
    tick();

    // Reset during ALLOCATE
    req(32'h0000_3040, 4'hF, 4'h0, '0);
    tick();
    idle_in();
    chk("rs_read", dfp_read, 1'b1);
    chk("rs_addr", dfp_addr, 32'h0000_3040);
    rst = 1'b1;
    tick();
    chk("rs_dropread", dfp_read, 1'b0);
    chk("rs_noresp",   ufp_resp, 1'b0);
    rst = 1'b0;
    tick();
    chk("rs_noresp2", ufp_resp, 1'b0);
    chk("rs_idle",    dfp_read, 1'b0);
    req(32'h0000_3040, 4'hF, 4'h0, '0);
    tick();
    idle_in();
    chk("rs_remiss", dfp_read, 1'b1);
    chk("rs_readdr", dfp_addr, 32'h0000_3040);
    dfp_rdata = l4;
    dfp_resp  = 1'b1;
    tick();
    dfp_resp = 1'b0;
    // Back-to-back hits right behind the fill response
    req(32'h0000_3044, 4'hF, 4'h0, '0);
    tick();
    chk("rs_resp",  ufp_resp,  1'b1);
    chk("rs_rdata", ufp_rdata, 32'h4444_0000);
    tick();
    req(32'h0000_3048, 4'hF, 4'h0, '0);
    chk("b2b1_resp",  ufp_resp,  1'b1);
    chk("b2b1_rdata", ufp_rdata, 32'h4444_0001);
    tick();
    idle_in();
    chk("b2b2_resp",  ufp_resp,  1'b1);
    chk("b2b2_rdata", ufp_rdata, 32'h4444_0002);
    tick();
    chk("b2b_end", ufp_resp, 1'b0);

    // Write miss: merge applied in FILL_DONE
    req(32'h0000_4060, 4'h0, 4'b1000, 32'hAB00_0000);
    tick();
    idle_in();
    chk("wm_read", dfp_read, 1'b1);
    chk("wm_addr", dfp_addr, 32'h0000_4060);
    dfp_rdata = l5;
    dfp_resp  = 1'b1;
    tick();
    dfp_resp = 1'b0;
    tick();
    chk("wm_resp", ufp_resp, 1'b1);
    req(32'h0000_4060, 4'hF, 4'h0, '0);
    tick();
    idle_in();
    chk("wm_rd_resp",  ufp_resp,  1'b1);
    chk("wm_rd_rdata", ufp_rdata, 32'hAB55_0000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
